// File: rtl/store_drain.sv
// Post-commit store buffer: holds executed stores by store ID, marks them committed,
// and drains committed stores to L1 in store-ID order over a request/grant handshake.
module store_drain #(
  parameter int cwd = 4,
  parameter int ewd = 4,
  parameter int ssz = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redir,
  input  logic [cwd-1:0]    com_valid,
  input  logic [cwd*8-1:0]  com_stid,
  input  logic [ewd-1:0]    st_wena,
  input  logic [ewd*8-1:0]  st_wstid,
  input  logic [ewd*64-1:0] st_waddr,
  input  logic [ewd*64-1:0] st_wdata,
  input  logic [ewd*8-1:0]  st_wmask,
  output logic              mem_req,
  output logic [63:0]       mem_addr,
  output logic [63:0]       mem_data,
  output logic [7:0]        mem_mask,
  input  logic              mem_gnt,
  output logic [7:0]        head_stid,
  output logic              drain_busy,
  output logic              drained
);

  localparam int IW = $clog2(ssz);

  typedef enum logic {IDLE, REQ} state_t;

  state_t         r_state;
  logic [ssz-1:0] r_rdy;
  logic [ssz-1:0] r_cmt;
  logic [63:0]    r_addr [ssz];
  logic [63:0]    r_data [ssz];
  logic [7:0]     r_mask [ssz];
  logic [7:0]     r_head;
  logic [7:0]     r_cmtTail;
  logic           r_memReq;
  logic [63:0]    r_memAddr;
  logic [63:0]    r_memData;
  logic [7:0]     r_memMask;
  logic           r_drained;

  logic [ssz-1:0] w_comHit;
  logic [7:0]     w_comCnt;
  logic [ssz-1:0] w_rdyNext;
  logic [ssz-1:0] w_cmtNext;
  logic [IW-1:0]  w_headIdx;
  logic [7:0]     w_nextStid;
  logic [IW-1:0]  w_nextIdx;
  logic           w_headCmt;
  logic           w_nextCmt;
  logic           w_grant;
  logic           w_unusedStidBits;

  assign w_headIdx  = r_head[IW-1:0];
  assign w_nextStid = r_head + 8'd1;
  assign w_nextIdx  = w_nextStid[IW-1:0];
  assign w_grant    = (r_state == REQ) && mem_gnt;

  // Only the low index bits of store IDs address the buffer.
  assign w_unusedStidBits = ^{com_stid, st_wstid};

  always_comb begin
    w_comHit = '0;
    w_comCnt = '0;
    for (int i = 0; i < cwd; i++) begin
      if (com_valid[i]) begin
        w_comHit[com_stid[i*8 +: IW]] = 1'b1;
        w_comCnt = w_comCnt + 8'd1;
      end
    end
  end

  // Same-cycle commits count, so a commit in cycle t can raise mem_req in t+1.
  assign w_headCmt = r_cmt[w_headIdx] | w_comHit[w_headIdx];
  assign w_nextCmt = r_cmt[w_nextIdx] | w_comHit[w_nextIdx];

  always_comb begin
    w_rdyNext = r_rdy;
    w_cmtNext = r_cmt | w_comHit;
    if (w_grant) begin
      w_rdyNext[w_headIdx] = 1'b0;
      w_cmtNext[w_headIdx] = 1'b0;
    end
    // Redirect squashes uncommitted entries; lanes committing this cycle survive.
    if (redir) begin
      w_rdyNext = w_rdyNext & (r_cmt | w_comHit);
    end else begin
      for (int j = 0; j < ewd; j++) begin
        if (st_wena[j]) begin
          w_rdyNext[st_wstid[j*8 +: IW]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy <= '0;
      r_cmt <= '0;
    end else begin
      r_rdy <= w_rdyNext;
      r_cmt <= w_cmtNext;
    end
  end

  // Ascending lane order lets the higher lane win on a same-index collision.
  always_ff @(posedge clk) begin
    if (!redir) begin
      for (int j = 0; j < ewd; j++) begin
        if (st_wena[j]) begin
          r_addr[st_wstid[j*8 +: IW]] <= st_waddr[j*64 +: 64];
          r_data[st_wstid[j*8 +: IW]] <= st_wdata[j*64 +: 64];
          r_mask[st_wstid[j*8 +: IW]] <= st_wmask[j*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
      r_memData <= '0;
      r_memMask <= '0;
      r_head    <= '0;
      r_cmtTail <= '0;
      r_drained <= 1'b0;
    end else begin
      r_cmtTail <= r_cmtTail + w_comCnt;
      r_drained <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_headCmt) begin
            r_state   <= REQ;
            r_memReq  <= 1'b1;
            r_memAddr <= r_addr[w_headIdx] & ~64'h7;
            r_memData <= r_data[w_headIdx];
            r_memMask <= r_mask[w_headIdx];
          end
        end
        REQ: begin
          if (mem_gnt) begin
            r_head    <= w_nextStid;
            r_drained <= 1'b1;
            if (w_nextCmt) begin
              r_memAddr <= r_addr[w_nextIdx] & ~64'h7;
              r_memData <= r_data[w_nextIdx];
              r_memMask <= r_mask[w_nextIdx];
            end else begin
              r_state  <= IDLE;
              r_memReq <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = r_memReq;
  assign mem_addr   = r_memAddr;
  assign mem_data   = r_memData;
  assign mem_mask   = r_memMask;
  assign head_stid  = r_head;
  assign drain_busy = (r_cmtTail != r_head);
  assign drained    = r_drained;

endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: directed vector table, redirect/reset sequences, then
// randomized traffic checked against an in-order store queue model.
module tb_store_drain;

  localparam int CWD = 4;
  localparam int EWD = 4;
  localparam int SSZ = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              redir;
  logic [CWD-1:0]    comValid;
  logic [CWD*8-1:0]  comStid;
  logic [EWD-1:0]    stWena;
  logic [EWD*8-1:0]  stWstid;
  logic [EWD*64-1:0] stWaddr;
  logic [EWD*64-1:0] stWdata;
  logic [EWD*8-1:0]  stWmask;
  logic              memReq;
  logic [63:0]       memAddr;
  logic [63:0]       memData;
  logic [7:0]        memMask;
  logic              memGnt;
  logic [7:0]        headStid;
  logic              drainBusy;
  logic              drained;

  int checks = 0;
  int errors = 0;

  // Model: payload and readiness per 8-bit store ID, plus monotonic counters.
  logic [63:0] mAddr [256];
  logic [63:0] mData [256];
  logic [7:0]  mMask [256];
  bit          mRdy  [256];
  int          headCnt;
  int          cmtCnt;
  int          allocCnt;
  int          grants;
  bit          lastGrant;

  typedef struct {
    logic [3:0]  wen;
    logic [7:0]  wStid;
    logic [63:0] wAddr;
    logic [63:0] wData;
    logic [7:0]  wMask;
    logic [3:0]  cValid;
    logic [7:0]  cStid;
    logic        gnt;
    logic        eReq;
    logic [63:0] eAddr;
    logic [63:0] eData;
    logic [7:0]  eMask;
    logic [7:0]  eHead;
    logic        eBusy;
    logic        eDrained;
  } vec_t;

  vec_t vecs [19];

  store_drain #(.cwd(CWD), .ewd(EWD), .ssz(SSZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .redir      (redir),
    .com_valid  (comValid),
    .com_stid   (comStid),
    .st_wena    (stWena),
    .st_wstid   (stWstid),
    .st_waddr   (stWaddr),
    .st_wdata   (stWdata),
    .st_wmask   (stWmask),
    .mem_req    (memReq),
    .mem_addr   (memAddr),
    .mem_data   (memData),
    .mem_mask   (memMask),
    .mem_gnt    (memGnt),
    .head_stid  (headStid),
    .drain_busy (drainBusy),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    redir    = 1'b0;
    comValid = '0;
    comStid  = '0;
    stWena   = '0;
    stWstid  = '0;
    stWaddr  = '0;
    stWdata  = '0;
    stWmask  = '0;
    memGnt   = 1'b0;
  endtask

  task automatic writeLane(input int lane, input logic [7:0] stid, input logic [63:0] addr,
                           input logic [63:0] data, input logic [7:0] mask);
    stWena[lane]           = 1'b1;
    stWstid[lane*8 +: 8]   = stid;
    stWaddr[lane*64 +: 64] = addr;
    stWdata[lane*64 +: 64] = data;
    stWmask[lane*8 +: 8]   = mask;
  endtask

  task automatic commitLane(input int lane, input logic [7:0] stid);
    comValid[lane]       = 1'b1;
    comStid[lane*8 +: 8] = stid;
  endtask

  function automatic vec_t mkVec(
    input logic [3:0] wen, input logic [7:0] wStid, input logic [63:0] wAddr,
    input logic [63:0] wData, input logic [7:0] wMask, input logic [3:0] cValid,
    input logic [7:0] cStid, input logic gnt, input logic eReq, input logic [63:0] eAddr,
    input logic [63:0] eData, input logic [7:0] eMask, input logic [7:0] eHead,
    input logic eBusy, input logic eDrained);
    vec_t v;
    v.wen = wen; v.wStid = wStid; v.wAddr = wAddr; v.wData = wData; v.wMask = wMask;
    v.cValid = cValid; v.cStid = cStid; v.gnt = gnt;
    v.eReq = eReq; v.eAddr = eAddr; v.eData = eData; v.eMask = eMask;
    v.eHead = eHead; v.eBusy = eBusy; v.eDrained = eDrained;
    return v;
  endfunction

  // Lane j of a vector writes stid wStid+j at wAddr+8j with data wData+j; commits likewise.
  task automatic applyStimulus(input vec_t v);
    clearInputs();
    for (int j = 0; j < EWD; j++) begin
      if (v.wen[j]) writeLane(j, v.wStid + 8'(j), v.wAddr + 64'(8 * j), v.wData + 64'(j), v.wMask);
    end
    for (int i = 0; i < CWD; i++) begin
      if (v.cValid[i]) commitLane(i, v.cStid + 8'(i));
    end
    memGnt = v.gnt;
  endtask

  task automatic checkVec(input int k, input vec_t v);
    checkOutput($sformatf("vec%0d.req", k), memReq, v.eReq);
    if (v.eReq) begin
      checkOutput($sformatf("vec%0d.addr", k), memAddr, v.eAddr);
      checkOutput($sformatf("vec%0d.data", k), memData, v.eData);
      checkOutput($sformatf("vec%0d.mask", k), memMask, v.eMask);
    end
    checkOutput($sformatf("vec%0d.head", k), headStid, v.eHead);
    checkOutput($sformatf("vec%0d.busy", k), drainBusy, v.eBusy);
    checkOutput($sformatf("vec%0d.drained", k), drained, v.eDrained);
  endtask

  // The oldest committed, ungranted store is always on the bus; nothing else is.
  task automatic checkModel(input string tag);
    bit expReq;
    logic [7:0] h;
    expReq = (cmtCnt != headCnt);
    h = 8'(headCnt);
    checkOutput({tag, ".req"}, memReq, expReq);
    if (expReq) begin
      checkOutput({tag, ".addr"}, memAddr, mAddr[h] & ~64'h7);
      checkOutput({tag, ".data"}, memData, mData[h]);
      checkOutput({tag, ".mask"}, memMask, mMask[h]);
    end
    checkOutput({tag, ".head"}, headStid, h);
    checkOutput({tag, ".busy"}, drainBusy, expReq);
    checkOutput({tag, ".drained"}, drained, lastGrant);
  endtask

  task automatic randomCycle(input bit allowNew);
    bit gnt, grantNow, redirNow;
    int nCom, c, w;
    logic [7:0] s;
    bit wrEn [EWD];
    int wrStid [EWD];
    logic [63:0] wrA [EWD];
    logic [63:0] wrD [EWD];
    logic [7:0] wrM [EWD];

    checkModel("rnd");
    clearInputs();
    gnt      = allowNew ? ($urandom_range(0, 3) != 0) : 1'b1;
    grantNow = (cmtCnt != headCnt) && gnt;
    redirNow = allowNew && ($urandom_range(0, 39) == 0);

    nCom = allowNew ? $urandom_range(0, CWD) : 0;
    c = 0;
    for (int i = 0; i < nCom; i++) begin
      s = 8'(cmtCnt + i);
      if (c == i && (cmtCnt + i) < allocCnt && mRdy[s]) begin
        commitLane(i, s);
        c++;
      end
    end

    w = 0;
    for (int j = 0; j < EWD; j++) begin
      wrEn[j] = 1'b0;
      wrStid[j] = 0;
      if (!allowNew) begin
        wrEn[j] = 1'b0;
      end else if (j == EWD - 1 && wrEn[0] && $urandom_range(0, 5) == 0) begin
        wrEn[j] = 1'b1;
        wrStid[j] = wrStid[0];
      end else if ($urandom_range(0, 1) == 1 && (allocCnt + w - headCnt) < SSZ) begin
        wrEn[j] = 1'b1;
        wrStid[j] = allocCnt + w;
        w++;
      end
      wrA[j] = {$urandom, $urandom};
      wrD[j] = {$urandom, $urandom};
      wrM[j] = 8'($urandom);
      if (wrEn[j]) writeLane(j, 8'(wrStid[j]), wrA[j], wrD[j], wrM[j]);
    end

    memGnt = gnt;
    redir  = redirNow;
    tick();

    if (!redirNow) begin
      for (int j = 0; j < EWD; j++) begin
        if (wrEn[j]) begin
          s = 8'(wrStid[j]);
          mAddr[s] = wrA[j];
          mData[s] = wrD[j];
          mMask[s] = wrM[j];
          mRdy[s]  = 1'b1;
        end
      end
    end
    allocCnt += w;
    cmtCnt   += c;
    if (redirNow) begin
      for (int k = cmtCnt; k < allocCnt; k++) mRdy[8'(k)] = 1'b0;
      allocCnt = cmtCnt;
    end
    if (grantNow) begin
      mRdy[8'(headCnt)] = 1'b0;
      headCnt++;
      grants++;
    end
    lastGrant = grantNow;
  endtask

  initial begin
    // Single store, 4-lane burst under continuous grant, 5-cycle backpressure.
    vecs[0]  = mkVec(4'b0001, 8'd0, 64'h8000_1004, 64'hAB, 8'h10, 4'b0000, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0);
    vecs[1]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0001, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd0, 1'b0, 1'b0);
    vecs[2]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h8000_1000, 64'hAB, 8'h10, 8'd0, 1'b1, 1'b0);
    vecs[3]  = mkVec(4'b1111, 8'd1, 64'h1000, 64'h100, 8'hFF, 4'b0000, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd1, 1'b0, 1'b1);
    vecs[4]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b1111, 8'd1, 1'b1, 1'b0, 64'h0, 64'h0, 8'h00, 8'd1, 1'b0, 1'b0);
    vecs[5]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h1000, 64'h100, 8'hFF, 8'd1, 1'b1, 1'b0);
    vecs[6]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h1008, 64'h101, 8'hFF, 8'd2, 1'b1, 1'b1);
    vecs[7]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h1010, 64'h102, 8'hFF, 8'd3, 1'b1, 1'b1);
    vecs[8]  = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h1018, 64'h103, 8'hFF, 8'd4, 1'b1, 1'b1);
    vecs[9]  = mkVec(4'b0001, 8'd5, 64'h2000, 64'h55, 8'h0F, 4'b0000, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd5, 1'b0, 1'b1);
    vecs[10] = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0001, 8'd5, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd5, 1'b0, 1'b0);
    for (int k = 11; k <= 15; k++) begin
      vecs[k] = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b0, 1'b1, 64'h2000, 64'h55, 8'h0F, 8'd5, 1'b1, 1'b0);
    end
    vecs[16] = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b1, 1'b1, 64'h2000, 64'h55, 8'h0F, 8'd5, 1'b1, 1'b0);
    vecs[17] = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd6, 1'b0, 1'b1);
    vecs[18] = mkVec(4'b0000, 8'd0, 64'h0, 64'h0, 8'h00, 4'b0000, 8'd0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 8'd6, 1'b0, 1'b0);

    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset.req", memReq, 1'b0);
    checkOutput("reset.addr", memAddr, 64'h0);
    checkOutput("reset.data", memData, 64'h0);
    checkOutput("reset.mask", memMask, 8'h0);
    checkOutput("reset.head", headStid, 8'd0);
    checkOutput("reset.busy", drainBusy, 1'b0);
    checkOutput("reset.drained", drained, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < 19; k++) begin
      checkVec(k, vecs[k]);
      applyStimulus(vecs[k]);
      tick();
    end

    // Redirect: 6,7 committed, 8,9 written only; a write during redirect is dropped.
    clearInputs();
    for (int j = 0; j < 4; j++) writeLane(j, 8'(6 + j), 64'h3000 + 64'(8 * j), 64'h600 + 64'(j), 8'hFF);
    tick();
    clearInputs();
    commitLane(0, 8'd6);
    commitLane(1, 8'd7);
    tick();
    checkOutput("redir.req", memReq, 1'b1);
    checkOutput("redir.addr", memAddr, 64'h3000);
    clearInputs();
    redir = 1'b1;
    writeLane(0, 8'd10, 64'h4000, 64'hDEAD, 8'hFF);
    tick();
    checkOutput("redir.rdy6", dut.r_rdy[6], 1'b1);
    checkOutput("redir.rdy7", dut.r_rdy[7], 1'b1);
    checkOutput("redir.rdy8", dut.r_rdy[8], 1'b0);
    checkOutput("redir.rdy9", dut.r_rdy[9], 1'b0);
    checkOutput("redir.rdy10", dut.r_rdy[10], 1'b0);
    checkOutput("redir.holdReq", memReq, 1'b1);
    checkOutput("redir.holdData", memData, 64'h600);
    checkOutput("redir.busy", drainBusy, 1'b1);
    clearInputs();
    memGnt = 1'b1;
    tick();
    checkOutput("redir.head7", headStid, 8'd7);
    checkOutput("redir.drain7", drained, 1'b1);
    checkOutput("redir.req7", memReq, 1'b1);
    checkOutput("redir.addr7", memAddr, 64'h3008);
    checkOutput("redir.data7", memData, 64'h601);
    tick();
    checkOutput("redir.head8", headStid, 8'd8);
    checkOutput("redir.idleReq", memReq, 1'b0);
    checkOutput("redir.idleBusy", drainBusy, 1'b0);
    clearInputs();
    writeLane(0, 8'd8, 64'h5005, 64'hBEEF, 8'h3C);
    tick();
    clearInputs();
    commitLane(0, 8'd8);
    tick();
    checkOutput("rewrite.req", memReq, 1'b1);
    checkOutput("rewrite.addr", memAddr, 64'h5000);
    checkOutput("rewrite.data", memData, 64'hBEEF);
    checkOutput("rewrite.mask", memMask, 8'h3C);
    clearInputs();
    memGnt = 1'b1;
    tick();
    checkOutput("rewrite.head", headStid, 8'd9);
    checkOutput("rewrite.drained", drained, 1'b1);
    checkOutput("rewrite.busy", drainBusy, 1'b0);

    // Reset while a request is waiting for grant.
    clearInputs();
    writeLane(0, 8'd9, 64'h6000, 64'h99, 8'h01);
    tick();
    clearInputs();
    commitLane(0, 8'd9);
    tick();
    checkOutput("rstReq.req", memReq, 1'b1);
    clearInputs();
    rst = 1'b1;
    tick();
    checkOutput("rstReq.req0", memReq, 1'b0);
    checkOutput("rstReq.head", headStid, 8'd0);
    checkOutput("rstReq.busy", drainBusy, 1'b0);
    checkOutput("rstReq.drained", drained, 1'b0);
    checkOutput("rstReq.addr", memAddr, 64'h0);
    rst = 1'b0;

    // Randomized traffic with redirects and wrap-around.
    headCnt = 0;
    cmtCnt = 0;
    allocCnt = 0;
    grants = 0;
    lastGrant = 1'b0;
    for (int k = 0; k < 256; k++) begin
      mRdy[k] = 1'b0;
      mAddr[k] = '0;
      mData[k] = '0;
      mMask[k] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) randomCycle(1'b1);
    for (int cyc = 0; cyc < 3 * SSZ && cmtCnt != headCnt; cyc++) randomCycle(1'b0);
    checkModel("final");
    checkOutput("final.drainedAll", (cmtCnt == headCnt), 1'b1);
    checkOutput("final.wrapped", (grants >= 300), 1'b1);
    $display("[TB] random phase granted %0d stores", grants);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
